qsys_system_button_pio: RTL and testbench
=========================================

# qsys_system_button_pio

Parametrised Avalon-MM button input peripheral. It supersedes the fixed 2-bit button PIO and adds:
- `WIDTH` channels with per-channel debounce;
- a software-selectable edge polarity per channel;
- a write-1-to-clear edge-capture register and a masked level interrupt.

It sits in the Qsys system between the board push-buttons and the Nios II data master, and raises the IRQ that the alarm/jukebox firmware services.

## Interface
Parameters:
- `WIDTH`, 4: number of button channels, 1..32.
- `DEBOUNCE_CYCLES`, 250000: clocks an input must hold a new level before it is accepted (5 ms at 50 MHz). Minimum 1.
- `IDLE_LEVEL`, 1: reset value of every debounced level. Buttons are active-low and idle high.

Ports:
- `clk` input 1: system clock.
- `reset_n` input 1: reset, asynchronous, active-low; clock `clk`.
- `in_port` input `WIDTH`: raw asynchronous button pins.
- `address` input 2: register select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe.
- `writedata` input 32: write data. Bits above `WIDTH` are ignored.
- `readdata` output 32: registered read data. Zero-extended above `WIDTH`.
- `irq` output 1: level interrupt, `|(edge_capture & irq_mask)`.

## Operation
Register map (`address`):
- 0 `DATA` (RO): debounced levels. Writes are ignored.
- 1 `POLARITY` (RW): per bit, 0 = capture falling edge (press), 1 = capture rising edge (release).
- 2 `IRQ_MASK` (RW): per-bit interrupt enable.
- 3 `EDGE_CAPTURE` (R/W1C): writing 1 to a bit clears it; writing 0 leaves it unchanged.

Input path, per channel:
- A 2-flop synchronizer `sync1`/`sync2` feeds the debouncer.
- Debouncer holds `stable` and a counter of width `$clog2(DEBOUNCE_CYCLES)` (minimum 1).
- While `sync2 == stable`: counter holds 0.
- While `sync2 != stable`: counter increments each clock.
- When the counter equals `DEBOUNCE_CYCLES-1` and `sync2 != stable`: `stable <= sync2`, the counter clears, and a one-clock `update` pulse fires.
- A mismatch shorter than `DEBOUNCE_CYCLES` clocks (a glitch) clears the counter. `stable` is unchanged and nothing is captured.

Edge capture, per bit:
- An `update` with new `stable` = 0 while `POLARITY[i]` = 0, or new `stable` = 1 while `POLARITY[i]` = 1, sets `EDGE_CAPTURE[i]`.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins, so no press is lost.
- A W1C clear of other bits never disturbs a bit being set.
- Changing `POLARITY` does not alter existing capture bits.

Bus:
- A write takes effect when `chipselect` = 1 and `write_n` = 0.
- Reads have no side effects.
- `readdata` updates every clock from `address`, regardless of `chipselect`.

Reset values:
- `readdata` = 0, `irq` = 0.
- `IRQ_MASK` = 0, `POLARITY` = 0, `EDGE_CAPTURE` = 0.
- Counters = 0; `sync1`, `sync2` and `stable` = `{WIDTH{IDLE_LEVEL}}`.

A reset asserted mid-debounce discards the partial count and all pending edges.

## Timing
- Read latency is 1 clock: `readdata` is valid on the edge after `address` is presented. Avalon `readLatency` = 1; no wait states.
- Write latency: a register write is visible on the next clock. `irq` reflects a mask or W1C change in the same clock the register changes.
- Input latency: count edge k as the first edge that samples a new, held level. `stable`, `DATA` and `EDGE_CAPTURE` change on edge k+`DEBOUNCE_CYCLES`+1. `irq` asserts combinationally from that edge.
- `irq` stays high until software clears every masked capture bit or masks it.

## Configuration
Macro `BUTTON_PIO_DEBOUNCE_EN`:
- Defined: the debounce counters are built as described in Operation.
- Undefined: counters are not instantiated. `stable <= sync2` every clock and `DEBOUNCE_CYCLES` is ignored, which behaves exactly as `DEBOUNCE_CYCLES` = 1. Input latency becomes edge k+2, and glitches of 1 clock or longer are captured.

## Structure
- Shared package `button_pio_pkg`:
  - address constants `ADDR_DATA`=0, `ADDR_POLARITY`=1, `ADDR_IRQ_MASK`=2, `ADDR_EDGE_CAPTURE`=3;
  - default `DEBOUNCE_CYCLES`.
- Sub-module `button_debounce`: one channel, containing the synchronizer, counter, `stable` and `update`. It is instantiated `WIDTH` times in a generate loop, and `BUTTON_PIO_DEBOUNCE_EN` is resolved inside it.
- Registers, edge logic and read mux live in the top module.

## Test plan
All scenarios use `WIDTH`=2 and `DEBOUNCE_CYCLES`=4, with the macro defined unless stated.
- Reset check: after reset, read addresses 0..3 → 0x3, 0x0, 0x0, 0x0; `irq` = 0.
- Debounced press: write `IRQ_MASK`=0x1, then drive `in_port[0]` 1→0 and hold. `EDGE_CAPTURE` = 0x1 and `irq` = 1 exactly on edge k+5; `DATA` = 0x2.
- Glitch rejection: a 3-clock low pulse on `in_port[1]` leaves `DATA` = 0x3 and `EDGE_CAPTURE` = 0, and `irq` stays 0.
- Release polarity and W1C: write `POLARITY`=0x2, press then release bit 1. Capture is set only on the release. Writing 0x1 to address 3 leaves the bit set; writing 0x2 clears it and `irq` drops.
- Simultaneous set and clear: a W1C of bit 0 on the same edge as bit 0's update leaves bit 0 = 1.
- Macro undefined: a held change on bit 0 is captured on edge k+2, and a 1-clock pulse is captured.

Source files
------------

// File: rtl/button_pio_pkg.sv
// Shared constants for the button PIO: register map and default debounce length.
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_POLARITY     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

  // 5 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchronizer followed by a debouncer.
// BUTTON_PIO_DEBOUNCE_EN builds the hold counter; otherwise stable follows sync2 each clock.
module button_debounce
  import button_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_i,
  output logic stable_o,
  output logic update_o,
  output logic level_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("button_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1_q, sync2_q;
  logic stable_q, stable_d;
  logic mismatch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= IDLE_LEVEL;
      sync2_q  <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end
  end

  assign mismatch = (sync2_q != stable_q);

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Any return to the stable level restarts the hold window, so glitches leave no trace.
  always_comb begin
    update_o = mismatch && (cnt_q == CNT_LAST);
    stable_d = stable_q;
    cnt_d    = '0;
    if (update_o)      stable_d = sync2_q;
    else if (mismatch) cnt_d    = cnt_q + 1'b1;
  end
`else
  always_comb begin
    update_o = mismatch;
    stable_d = sync2_q;
  end
`endif

  assign stable_o = stable_q;
  assign level_o  = sync2_q;

endmodule

// File: rtl/qsys_system_button_pio.sv
// Avalon-MM button PIO: WIDTH debounced channels, per-bit edge polarity, W1C capture, masked IRQ.
// Debounce counters are built only when BUTTON_PIO_DEBOUNCE_EN is defined.
module qsys_system_button_pio
  import button_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("qsys_system_button_pio: WIDTH must be 1..32");
  end

  logic [WIDTH-1:0] data_w, update_w, level_w, set_w, clr_w;
  logic [WIDTH-1:0] pol_q, pol_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rd_q, rd_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .din_i    (in_port[i]),
      .stable_o (data_w[i]),
      .update_o (update_w[i]),
      .level_o  (level_w[i])
    );
  end

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  // Polarity 0 selects a new level of 0 (press), 1 selects a new level of 1 (release).
  assign set_w = update_w & ~(level_w ^ pol_q);

  always_comb begin
    pol_d  = pol_q;
    mask_d = mask_q;
    clr_w  = '0;
    if (wr_en) begin
      case (address)
        ADDR_POLARITY:     pol_d  = writedata[WIDTH-1:0];
        ADDR_IRQ_MASK:     mask_d = writedata[WIDTH-1:0];
        ADDR_EDGE_CAPTURE: clr_w  = writedata[WIDTH-1:0];
        default:           ;
      endcase
    end
    // A set on the same clock as its clear wins so no press is lost.
    cap_d = (cap_q & ~clr_w) | set_w;
  end

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:         rd_d[WIDTH-1:0] = data_w;
      ADDR_POLARITY:     rd_d[WIDTH-1:0] = pol_q;
      ADDR_IRQ_MASK:     rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAPTURE: rd_d[WIDTH-1:0] = cap_q;
      default:           rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pol_q  <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      rd_q   <= '0;
    end else begin
      pol_q  <= pol_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_qsys_system_button_pio.sv
// Bench for qsys_system_button_pio (WIDTH=2, DEBOUNCE_CYCLES=4): directed scenarios plus
// a per-cycle comparison against a window-based behavioural model.
module tb_qsys_system_button_pio;

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int D_EFF = 4;
`else
  localparam int D_EFF = 1;
`endif
  localparam int LAT = D_EFF + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  in_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  qsys_system_button_pio #(
    .WIDTH           (2),
    .DEBOUNCE_CYCLES (4),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a channel's level flips once the last D_EFF pin samples (delayed two clocks
  // by the synchronizer) all disagree with the currently accepted level.
  logic [1:0]  m_hist [0:7];
  logic [1:0]  m_st, m_pol, m_mask, m_cap, m_set, m_clr, m_st_n;
  logic [31:0] m_rd;
  bit          m_all;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int j = 0; j < 8; j++) m_hist[j] = 2'b11;
      m_st = 2'b11; m_pol = 2'b00; m_mask = 2'b00; m_cap = 2'b00; m_rd = 32'h0;
    end else begin
      case (address)
        2'd0: m_rd = {30'h0, m_st};
        2'd1: m_rd = {30'h0, m_pol};
        2'd2: m_rd = {30'h0, m_mask};
        default: m_rd = {30'h0, m_cap};
      endcase
      m_set  = 2'b00;
      m_clr  = 2'b00;
      m_st_n = m_st;
      for (int b = 0; b < 2; b++) begin
        m_all = 1'b1;
        for (int j = 1; j <= D_EFF; j++)
          if (m_hist[j][b] == m_st[b]) m_all = 1'b0;
        if (m_all) begin
          m_st_n[b] = ~m_st[b];
          if (m_st_n[b] == m_pol[b]) m_set[b] = 1'b1;
        end
      end
      if (chipselect && !write_n) begin
        if (address == 2'd1) m_pol  = writedata[1:0];
        if (address == 2'd2) m_mask = writedata[1:0];
        if (address == 2'd3) m_clr  = writedata[1:0];
      end
      m_cap = (m_cap & ~m_clr) | m_set;
      m_st  = m_st_n;
      for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = in_port;
    end
  end

  always @(negedge clk) begin
    if (run && reset_n) begin
      chk("cyc_readdata", readdata, m_rd);
      chk("cyc_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    @(negedge clk);
    chk(name, readdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; in_port = 2'b11; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    idle(3);
    reset_n = 1'b1;
    run = 1'b1;

    read_check(2'd0, 32'h3, "reset_data");
    read_check(2'd1, 32'h0, "reset_polarity");
    read_check(2'd2, 32'h0, "reset_mask");
    read_check(2'd3, 32'h0, "reset_capture");
    chk("reset_irq", {31'h0, irq}, 32'h0);

    // Debounced press on bit 0
    bus_write(2'd2, 32'h1);
    address = 2'd3;
    in_port[0] = 1'b0;
    idle(LAT);
    chk("press_irq_early", {31'h0, irq}, 32'h0);
    idle(1);
    chk("press_irq_edge", {31'h0, irq}, 32'h1);
    read_check(2'd3, 32'h1, "press_capture");
    read_check(2'd0, 32'h2, "press_data");
    bus_write(2'd3, 32'h1);
    chk("press_w1c_irq", {31'h0, irq}, 32'h0);
    in_port[0] = 1'b1;
    idle(10);
    read_check(2'd3, 32'h0, "release_not_captured");
    read_check(2'd0, 32'h3, "release_data");

    // 3-clock low pulse on bit 1
    in_port[1] = 1'b0;
    idle(3);
    in_port[1] = 1'b1;
    idle(10);
    read_check(2'd0, 32'h3, "glitch_data");
`ifdef BUTTON_PIO_DEBOUNCE_EN
    read_check(2'd3, 32'h0, "glitch_capture");
`else
    read_check(2'd3, 32'h2, "glitch_capture");
`endif
    chk("glitch_irq", {31'h0, irq}, 32'h0);
    bus_write(2'd3, 32'h2);
    read_check(2'd3, 32'h0, "glitch_cleared");

    // Release polarity on bit 1 and W1C behaviour
    bus_write(2'd1, 32'h2);
    bus_write(2'd2, 32'h3);
    in_port[1] = 1'b0;
    idle(10);
    read_check(2'd3, 32'h0, "pol_press_ignored");
    chk("pol_press_irq", {31'h0, irq}, 32'h0);
    in_port[1] = 1'b1;
    idle(10);
    read_check(2'd3, 32'h2, "pol_release_capture");
    chk("pol_release_irq", {31'h0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    read_check(2'd3, 32'h2, "w1c_other_bit");
    chk("w1c_other_irq", {31'h0, irq}, 32'h1);
    bus_write(2'd3, 32'h2);
    read_check(2'd3, 32'h0, "w1c_clear");
    chk("w1c_clear_irq", {31'h0, irq}, 32'h0);

    // W1C of bit 0 landing on the same edge as bit 0's update
    in_port[0] = 1'b0;
    idle(LAT);
    bus_write(2'd3, 32'h1);
    read_check(2'd3, 32'h1, "set_beats_clear");
    chk("set_beats_clear_irq", {31'h0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    in_port[0] = 1'b1;
    idle(10);
    read_check(2'd3, 32'h0, "sim_cleared");

    // 1-clock low pulse on bit 0
    in_port[0] = 1'b0;
    idle(1);
    in_port[0] = 1'b1;
    idle(8);
`ifdef BUTTON_PIO_DEBOUNCE_EN
    read_check(2'd3, 32'h0, "pulse1_capture");
`else
    read_check(2'd3, 32'h1, "pulse1_capture");
`endif
    read_check(2'd0, 32'h3, "pulse1_data");

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
